// File: rtl/pll_strobe_gen_pkg.sv
// Shared types and elaboration helpers for the PLL-style strobe generator.
package pll_strobe_gen_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_LOCKING = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_RELOCK  = 3'd3,
    ST_BYPASS  = 3'd4
  } pll_state_t;

  // Settling counter must hold the larger of the two settle lengths without wrapping.
  function automatic int settle_cnt_w(input int lock_cycles, input int relock_cycles);
    int longest;
    longest = (lock_cycles > relock_cycles) ? lock_cycles : relock_cycles;
    return $clog2(longest + 1);
  endfunction

  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pll_strobe_gen_phase_acc.sv
// One strobe channel: phase increment register, accumulator and registered carry strobe.
module phase_acc #(
  parameter int               ACC_W     = 32,
  parameter logic [ACC_W-1:0] INIT_INCR = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             force_ce,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_data,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] incr_q;
  logic [ACC_W:0]   sum;

  // The carry out of the modulo add is the strobe: mean rate f_clk * incr / 2**ACC_W.
  assign sum = {1'b0, acc_q} + {1'b0, incr_q};

  // NOTE: every register here, including the increment, has an explicit reset value so
  // the channel restarts at the default rate after any reset, not at a stale setting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      incr_q <= INIT_INCR;
      ce     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (wr_en) begin
        incr_q <= wr_data;
      end
      if (clear) begin
        acc_q <= '0;
        ce    <= force_ce;
      end else if (run) begin
        acc_q <= sum[ACC_W-1:0];
        ce    <= sum[ACC_W];
      end else begin
        ce <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pll_strobe_gen.sv
// Clock-enable strobe generator with a PLL-like lock/relock sequencer in front of
// NUM_CH phase accumulators; this level holds only FSM, settling counter and write decode.
module pll_strobe_gen
  import pll_strobe_gen_pkg::*;
#(
  parameter int               NUM_CH        = 2,
  parameter int               ACC_W         = 32,
  parameter int               LOCK_CYCLES   = 1024,
  parameter int               RELOCK_CYCLES = 256,
  parameter logic [ACC_W-1:0] INIT_INCR     = {1'b1, {(ACC_W-1){1'b0}}},
  localparam int              CH_W          = ch_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bypass,
  input  logic              incr_valid,
  output logic              incr_ready,
  input  logic [CH_W-1:0]   incr_ch,
  input  logic [ACC_W-1:0]  incr_data,
  output logic [NUM_CH-1:0] ce,
  output logic              lock
);

  localparam int              CNT_W       = settle_cnt_w(LOCK_CYCLES, RELOCK_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOCK_LAST = CNT_W'(RELOCK_CYCLES - 1);
  localparam logic [CH_W:0]    NUM_CH_EXT  = (CH_W + 1)'(NUM_CH);

  pll_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_hit;
  logic             acc_run, acc_clear, acc_force;

  assign incr_ready = (state_q == ST_LOCKING) || (state_q == ST_LOCKED) ||
                      (state_q == ST_BYPASS);

  // Out-of-range channel writes still complete the handshake but touch nothing.
  assign wr_hit = incr_valid && incr_ready && ({1'b0, incr_ch} < NUM_CH_EXT);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d = bypass ? ST_BYPASS : ST_LOCKING;
        cnt_d   = '0;
      end
      ST_LOCKING: begin
        if (wr_hit) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (wr_hit) begin
          state_d = ST_RELOCK;
          cnt_d   = '0;
        end
      end
      ST_RELOCK: begin
        if (cnt_q == RELOCK_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BYPASS: begin
        if (!bypass) begin
          state_d = ST_LOCKING;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
    // Bypass overrides any write-triggered transition; the write itself still lands.
    if (bypass && (state_q != ST_RESET)) begin
      state_d = ST_BYPASS;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      lock    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock    <= (state_d == ST_LOCKED) || (state_d == ST_BYPASS);
    end
  end

  // Channel controls follow the state being entered, so ce/lock change on the transition edge.
  assign acc_run   = (state_d == ST_LOCKED);
  assign acc_clear = !acc_run;
  assign acc_force = (state_d == ST_BYPASS);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    phase_acc #(
      .ACC_W    (ACC_W),
      .INIT_INCR(INIT_INCR)
    ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .clear   (acc_clear),
      .run     (acc_run),
      .force_ce(acc_force),
      .wr_en   (wr_hit && (incr_ch == CH_W'(i))),
      .wr_data (incr_data),
      .ce      (ce[i])
    );
  end

endmodule

// File: tb/tb_pll_strobe_gen.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations, a negedge monitor compares.
module tb_pll_strobe_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       u0_bypass, u0_valid, u0_ready, u0_ch, u0_lock;
  logic [7:0] u0_data;
  logic [1:0] u0_ce;
  logic       u1_bypass, u1_valid, u1_ready, u1_lock;
  logic [1:0] u1_ch;
  logic [7:0] u1_data;
  logic [2:0] u1_ce;

  always #5 clk = ~clk;

  pll_strobe_gen #(
    .NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(16), .RELOCK_CYCLES(8), .INIT_INCR(8'd64)
  ) dut (
    .clk(clk), .rst(rst), .bypass(u0_bypass), .incr_valid(u0_valid),
    .incr_ready(u0_ready), .incr_ch(u0_ch), .incr_data(u0_data),
    .ce(u0_ce), .lock(u0_lock)
  );

  pll_strobe_gen #(
    .NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(16), .RELOCK_CYCLES(8), .INIT_INCR(8'd64)
  ) dut3 (
    .clk(clk), .rst(rst), .bypass(u1_bypass), .incr_valid(u1_valid),
    .incr_ready(u1_ready), .incr_ch(u1_ch), .incr_data(u1_data),
    .ce(u1_ce), .lock(u1_lock)
  );

  typedef struct {
    int         cyc;
    int         unit;
    logic       lk;
    logic [2:0] ce;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int cy, input logic [4:0] got,
                       input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d: got lock=%b rdy=%b ce=%b, expected lock=%b rdy=%b ce=%b",
               name, cy, got[4], got[3], got[2:0], want[4], want[3], want[2:0]);
    end
  endtask

  // Monitor: compares every expectation that has come due at this sample point.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.unit == 0)
        check(mon_e.name, cyc, {u0_lock, u0_ready, 1'b0, u0_ce},
              {mon_e.lk, mon_e.rdy, mon_e.ce});
      else
        check(mon_e.name, cyc, {u1_lock, u1_ready, u1_ce},
              {mon_e.lk, mon_e.rdy, mon_e.ce});
    end
  end

  task automatic expect_at(input int unit, input int k, input logic lk,
                           input logic [2:0] ce, input logic rdy, input string name);
    exp_t e;
    e.cyc = base + k; e.unit = unit; e.lk = lk; e.ce = ce; e.rdy = rdy; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer a write and hold it until accepted; returns one tick after the accepting edge.
  task automatic do_write(input int unit, input int ch, input logic [7:0] data);
    int waited;
    logic rdy;
    waited = 0;
    if (unit == 0) begin u0_valid = 1'b1; u0_ch = ch[0];   u0_data = data; end
    else           begin u1_valid = 1'b1; u1_ch = ch[1:0]; u1_data = data; end
    rdy = (unit == 0) ? u0_ready : u1_ready;
    while (!rdy && waited < 64) begin
      @(posedge clk); #1;
      waited++;
      rdy = (unit == 0) ? u0_ready : u1_ready;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL write_handshake unit=%0d ch=%0d: got ready=0 for %0d cycles, expected acceptance",
               unit, ch, waited);
    end else begin
      @(posedge clk); #1;
    end
    if (unit == 0) u0_valid = 1'b0; else u1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       lk, r;
    logic [2:0] c;
    rst = 1'b1;
    u0_bypass = 1'b0; u0_valid = 1'b0; u0_ch = 1'b0; u0_data = '0;
    u1_bypass = 1'b0; u1_valid = 1'b0; u1_ch = '0;   u1_data = '0;

    @(posedge clk); #1;
    base = cyc;
    expect_at(0, 0, 1'b0, 3'b000, 1'b0, "reset_hold");
    expect_at(1, 0, 1'b0, 3'b000, 1'b0, "reset_hold3");
    @(posedge clk); #1;

    // Release: 16 cycles of LOCKING, lock on the 17th edge, both channels strobe every 4th.
    base = cyc;
    for (int k = 0; k < 40; k++) begin
      lk = (k >= 17);
      r  = (k >= 1);
      c  = (lk && ((k - 16) % 4 == 0)) ? 3'b111 : 3'b000;
      expect_at(0, k, lk, c & 3'b011, r, "lock_acquire");
      expect_at(1, k, lk, c, r, "lock_acquire3");
    end
    rst = 1'b0;
    tick_to(base + 40);

    // Out-of-range channel on the 3-channel unit: accepted, no relock, same strobes.
    base = cyc;
    for (int k = 1; k <= 20; k++)
      expect_at(1, k, 1'b1, (k % 4 == 0) ? 3'b111 : 3'b000, 1'b1, "bad_ch_ignored");
    do_write(1, 3, 8'd128);
    tick_to(base + 21);

    // ch1=128 while locked: 8 dark cycles, then ch1 every 2, ch0 every 4.
    base = cyc;
    for (int k = 1; k <= 40; k++) begin
      lk = (k >= 9);
      c  = {1'b0, lk && ((k - 8) % 2 == 0), lk && ((k - 8) % 4 == 0)};
      expect_at(0, k, lk, c, lk, "relock_ch1_128");
    end
    do_write(0, 1, 8'd128);
    tick_to(base + 41);

    // Bypass with a simultaneous ch0=32 write: bypass wins, the write still lands.
    base = cyc;
    for (int k = 1; k <= 36; k++) begin
      if (k <= 4) begin
        lk = 1'b1; c = 3'b011;
      end else if (k <= 20) begin
        lk = 1'b0; c = 3'b000;
      end else begin
        lk = 1'b1;
        c  = {1'b0, (k - 20) % 2 == 0, (k - 20) % 8 == 0};
      end
      expect_at(0, k, lk, c, 1'b1, "bypass_then_lock");
    end
    u0_bypass = 1'b1;
    do_write(0, 0, 8'd32);
    tick_to(base + 4);
    u0_bypass = 1'b0;
    tick_to(base + 37);

    // ch0=0 then ch1=255 (second write waits out the first relock).
    base = cyc;
    for (int k = 1; k <= 290; k++) begin
      if (k <= 8 || (k >= 10 && k <= 17)) begin
        lk = 1'b0; r = 1'b0; c = 3'b000;
      end else if (k == 9) begin
        lk = 1'b1; r = 1'b1; c = 3'b000;
      end else begin
        lk = 1'b1; r = 1'b1;
        c  = {1'b0, (k - 18) % 256 != 0, 1'b0};
      end
      expect_at(0, k, lk, c, r, "incr_extremes");
    end
    do_write(0, 0, 8'd0);
    do_write(0, 1, 8'd255);
    tick_to(base + 291);

    // Reset mid-RELOCK: after release both channels back at the 64 default.
    base = cyc;
    for (int k = 1; k <= 40; k++) begin
      lk = (k >= 22);
      r  = (k >= 6);
      c  = (lk && ((k - 21) % 4 == 0)) ? 3'b011 : 3'b000;
      expect_at(0, k, lk, c, r, "reset_mid_relock");
    end
    do_write(0, 1, 8'd128);
    tick_to(base + 3);
    #1 rst = 1'b1;
    tick_to(base + 5);
    rst = 1'b0;
    tick_to(base + 41);

    // Reset must clear outputs before the next clock edge.
    base = cyc;
    expect_at(0, 0, 1'b0, 3'b000, 1'b0, "async_reset");
    #1 rst = 1'b1;
    tick_to(base + 2);
    rst = 1'b0;

    for (int n = 0; n < 8 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
